// File: rtl/fsm_terminal_buf.sv
// Command-line terminal controller: buffers UART bytes until TERM_CHAR, then starts the executor.
// Define TERM_BACKSPACE_EN to treat 8'h08/8'h7F as edit characters instead of data.
module fsm_terminal_buf #(
  parameter int                DATA_W      = 8,
  parameter int                DEPTH       = 16,
  parameter logic [DATA_W-1:0] TERM_CHAR   = DATA_W'('h0D),
  parameter int                TIMEOUT_CYC = 50_000_000
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         eor_i,
  input  logic [DATA_W-1:0]            rx_data_i,
  input  logic                         eofsm_i,
  output logic [DEPTH*DATA_W-1:0]      cmd_o,
  output logic [$clog2(DEPTH+1)-1:0]   len_o,
  output logic                         stfsm_o,
  output logic                         busy_o,
  output logic                         ovf_o,
  output logic                         tmo_o
);

  localparam int LEN_W = $clog2(DEPTH + 1);
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_RXING, S_CHECK, S_EXEC, S_WAIT_DONE
  } state_t;

  state_t                    state_q, state_d;
  logic [DEPTH*DATA_W-1:0]   cmd_q, cmd_d;
  logic [LEN_W-1:0]          len_q, len_d;
  logic                      disc_q, disc_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      is_term, is_edit, timing;

  assign is_term = (rx_data_i == TERM_CHAR);
`ifdef TERM_BACKSPACE_EN
  assign is_edit = (rx_data_i == DATA_W'('h08)) || (rx_data_i == DATA_W'('h7F));
`else
  assign is_edit = 1'b0;
`endif
  // The idle timer only matters once something (data or a discarded overflow) is pending.
  assign timing = (len_q != '0) || disc_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      len_q   <= '0;
      disc_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      len_q   <= len_d;
      disc_q  <= disc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    len_d   = len_q;
    disc_d  = disc_q;
    cnt_d   = cnt_q;
    stfsm_o = 1'b0;
    busy_o  = 1'b0;
    ovf_o   = 1'b0;
    tmo_o   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (eor_i) state_d = S_ARM;
      end
      S_ARM: begin
        if (timing && (cnt_q == CNT_MAX)) begin
          tmo_o   = 1'b1;
          state_d = S_IDLE;
        end else begin
          if (timing) cnt_d = cnt_q + 1'b1;
          if (!eor_i) state_d = S_RXING;
        end
      end
      S_RXING: begin
        if (eor_i) state_d = S_CHECK;
      end
      S_CHECK: begin
        cnt_d   = '0;
        state_d = S_ARM;
        if (is_term) begin
          if (disc_q)              state_d = S_IDLE;
          else if (len_q != '0)    state_d = S_EXEC;
        end else if (disc_q) begin
          // dropped: the line is already lost, only its terminator is awaited
        end else if (is_edit) begin
          if (len_q != '0) begin
            for (int k = 0; k < DEPTH; k++)
              if (len_q == LEN_W'(k + 1)) cmd_d[k*DATA_W +: DATA_W] = '0;
            len_d = len_q - 1'b1;
          end
        end else if (len_q == LEN_FULL) begin
          disc_d = 1'b1;
          ovf_o  = 1'b1;
        end else begin
          for (int k = 0; k < DEPTH; k++)
            if (len_q == LEN_W'(k)) cmd_d[k*DATA_W +: DATA_W] = rx_data_i;
          len_d = len_q + 1'b1;
        end
      end
      S_EXEC: begin
        stfsm_o = 1'b1;
        busy_o  = 1'b1;
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        busy_o = 1'b1;
        if (eofsm_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Entering or sitting in IDLE always leaves an empty buffer behind.
    if (state_d == S_IDLE) begin
      cmd_d  = '0;
      len_d  = '0;
      disc_d = 1'b0;
      cnt_d  = '0;
    end
  end

  assign cmd_o = cmd_q;
  assign len_o = len_q;

endmodule

// File: tb/tb_fsm_terminal_buf.sv
// Bench for fsm_terminal_buf: a default-size instance and a DEPTH=4 / TIMEOUT_CYC=100 instance.
// Handshake: a byte is presented by holding eor_i low, then raising it with rx_data_i stable.
module tb_fsm_terminal_buf;

  localparam int D0   = 16;
  localparam int D1   = 4;
  localparam int TMO1 = 100;

  typedef struct packed {
    logic [7:0]   len;
    logic [127:0] cmd;
  } exp_t;

  typedef struct {
    string        name;
    int           dut;
    logic [255:0] bytes;
    int           n;
    bit           exec;
    int           len;
    logic [127:0] cmd;
    int           ovf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        eor [2];
  logic [7:0]  rx [2];
  logic        eofsm [2];
  logic [D0*8-1:0] cmd0;
  logic [4:0]      len0;
  logic [D1*8-1:0] cmd1;
  logic [2:0]      len1;
  logic        stf [2];
  logic        busy [2];
  logic        ovf [2];
  logic        tmo [2];

  int   checks = 0;
  int   failures = 0;
  int   stf_cnt [2];
  int   ovf_cnt [2];
  int   tmo_cnt [2];
  exp_t exp_q[$];
  vec_t vecs[$];

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  fsm_terminal_buf u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .eor_i(eor[0]), .rx_data_i(rx[0]), .eofsm_i(eofsm[0]),
    .cmd_o(cmd0), .len_o(len0), .stfsm_o(stf[0]), .busy_o(busy[0]), .ovf_o(ovf[0]), .tmo_o(tmo[0])
  );

  fsm_terminal_buf #(.DEPTH(D1), .TIMEOUT_CYC(TMO1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .eor_i(eor[1]), .rx_data_i(rx[1]), .eofsm_i(eofsm[1]),
    .cmd_o(cmd1), .len_o(len1), .stfsm_o(stf[1]), .busy_o(busy[1]), .ovf_o(ovf[1]), .tmo_o(tmo[1])
  );

  // pulse counters, sampled away from the active edge
  initial begin
    for (int d = 0; d < 2; d++) begin
      stf_cnt[d] = 0;
      ovf_cnt[d] = 0;
      tmo_cnt[d] = 0;
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      stf_cnt[d] = stf_cnt[d] + int'(stf[d]);
      ovf_cnt[d] = ovf_cnt[d] + int'(ovf[d]);
      tmo_cnt[d] = tmo_cnt[d] + int'(tmo[d]);
    end
  end

  function automatic logic [127:0] get_cmd(input int d);
    return (d == 0) ? cmd0 : {96'b0, cmd1};
  endfunction

  function automatic int get_len(input int d);
    return (d == 0) ? int'(len0) : int'(len1);
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input int dut, input string s, input bit exec,
                              input int len, input logic [127:0] cmd, input int ovf_n);
    vec_t v;
    v.name  = name;
    v.dut   = dut;
    v.bytes = '0;
    for (int i = 0; i < s.len(); i++) v.bytes[i*8 +: 8] = s[i];
    v.bytes[s.len()*8 +: 8] = 8'h0D;
    v.n    = s.len() + 1;
    v.exec = exec;
    v.len  = len;
    v.cmd  = cmd;
    v.ovf  = ovf_n;
    return v;
  endfunction

  // driver tasks
  task automatic send_byte(input int d, input logic [7:0] b);
    @(negedge clk);
    eor[d] = 1'b0;
    rx[d]  = 8'($urandom_range(0, 255));
    repeat ($urandom_range(1, 3)) @(negedge clk);
    rx[d]  = b;
    eor[d] = 1'b1;
  endtask

  task automatic gap();
    repeat ($urandom_range(1, 4)) @(negedge clk);
  endtask

  task automatic send_line(input vec_t v);
    repeat (2) @(negedge clk);
    for (int i = 0; i < v.n; i++) begin
      send_byte(v.dut, v.bytes[i*8 +: 8]);
      if (i < v.n - 1) gap();
    end
  endtask

  // Called right after the terminator's eor_i rise; stfsm_o is due at the second falling edge.
  task automatic expect_exec(input int d, input string name);
    int   k;
    exp_t e;
    k = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (stf[d]) begin
        k = c;
        break;
      end
    end
    check({name, " stfsm_seen"}, k != 0, 1'b1);
    if (k != 0) begin
      check({name, " sb_nonempty"}, exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check({name, " len"}, get_len(d), e.len);
        check({name, " cmd"}, get_cmd(d), e.cmd);
      end
      check({name, " stfsm_latency"}, k, 2);
      check({name, " busy_exec"}, busy[d], 1'b1);
      @(negedge clk);
      check({name, " stfsm_one_cycle"}, stf[d], 1'b0);
      check({name, " busy_wait"}, busy[d], 1'b1);
    end else if (exp_q.size() != 0) begin
      exp_q.delete(0);
    end
  endtask

  task automatic finish_exec(input int d, input string name);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    check({name, " busy_held"}, busy[d], 1'b1);
    eofsm[d] = 1'b1;
    @(negedge clk);
    eofsm[d] = 1'b0;
    check({name, " busy_done"}, busy[d], 1'b0);
    check({name, " len_cleared"}, get_len(d), 0);
    check({name, " cmd_cleared"}, get_cmd(d), 128'h0);
  endtask

  task automatic run_line(input vec_t v);
    int stf0, ovf0;
    stf0 = stf_cnt[v.dut];
    ovf0 = ovf_cnt[v.dut];
    send_line(v);
    if (v.exec) begin
      exp_q.push_back({8'(v.len), v.cmd});
      expect_exec(v.dut, v.name);
      finish_exec(v.dut, v.name);
    end else begin
      repeat (4) @(negedge clk);
      check({v.name, " len_after"}, get_len(v.dut), 0);
      check({v.name, " cmd_after"}, get_cmd(v.dut), 128'h0);
    end
    check({v.name, " stfsm_count"}, stf_cnt[v.dut] - stf0, v.exec ? 1 : 0);
    check({v.name, " ovf_count"}, ovf_cnt[v.dut] - ovf0, v.ovf);
  endtask

  // Sends bytes without a terminator, then expects tmo_o on the 101st falling edge after the last rise.
  task automatic expect_timeout(input string name);
    int k;
    k = 0;
    for (int c = 1; c <= 150; c++) begin
      @(negedge clk);
      if (tmo[1]) begin
        k = c;
        break;
      end
    end
    check({name, " tmo_cycle"}, k, TMO1 + 1);
    @(negedge clk);
    check({name, " tmo_one_cycle"}, tmo[1], 1'b0);
    check({name, " len_after_tmo"}, get_len(1), 0);
    check({name, " cmd_after_tmo"}, get_cmd(1), 128'h0);
  endtask

  initial begin
    vec_t v;
    logic [127:0] rnd_cmd;
    int stf0;

    for (int d = 0; d < 2; d++) begin
      eor[d]   = 1'b1;
      rx[d]    = 8'h00;
      eofsm[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset len", get_len(d), 0);
      check("reset cmd", get_cmd(d), 128'h0);
      check("reset outs", {stf[d], busy[d], ovf[d], tmo[d]}, 4'b0000);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // table of whole lines
    vecs.push_back(mk("led1",     0, "LED1",    1, 4, 128'h3144454C, 0));
    vecs.push_back(mk("empty",    0, "",        0, 0, 128'h0, 0));
    vecs.push_back(mk("a_after",  0, "A",       1, 1, 128'h41, 0));
    vecs.push_back(mk("ovf5",     1, "ABCDE",   0, 0, 128'h0, 1));
    vecs.push_back(mk("xy",       1, "XY",      1, 2, 128'h5958, 0));
    vecs.push_back(mk("full4",    1, "WXYZ",    1, 4, 128'h5A595857, 0));
    vecs.push_back(mk("ovf7",     1, "ABCDEFG", 0, 0, 128'h0, 1));
`ifdef TERM_BACKSPACE_EN
    v = mk("bs_mid", 0, "AB?C", 1, 2, 128'h4341, 0);
`else
    v = mk("bs_mid", 0, "AB?C", 1, 4, 128'h43084241, 0);
`endif
    v.bytes[23:16] = 8'h08;
    vecs.push_back(v);
`ifdef TERM_BACKSPACE_EN
    v = mk("del_first", 1, "?A", 1, 1, 128'h41, 0);
`else
    v = mk("del_first", 1, "?A", 1, 2, 128'h417F, 0);
`endif
    v.bytes[7:0] = 8'h7F;
    vecs.push_back(v);

    rnd_cmd = '0;
    v = mk("rand16", 0, "", 1, D0, 128'h0, 0);
    for (int i = 0; i < D0; i++) begin
      v.bytes[i*8 +: 8] = 8'($urandom_range(8'h20, 8'h7E));
      rnd_cmd[i*8 +: 8] = v.bytes[i*8 +: 8];
    end
    v.bytes[D0*8 +: 8] = 8'h0D;
    v.n   = D0 + 1;
    v.cmd = rnd_cmd;
    vecs.push_back(v);

    foreach (vecs[i]) run_line(vecs[i]);

    // partial line times out, then a fresh line executes
    repeat (2) @(negedge clk);
    send_byte(1, "A");
    expect_timeout("tmo_partial");
    run_line(mk("after_tmo", 1, "B", 1, 1, 128'h42, 0));

    // overflowed line times out while discarding
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      send_byte(1, 8'(8'h41 + i));
      if (i < 4) gap();
    end
    expect_timeout("tmo_discard");
    run_line(mk("after_tmo_disc", 1, "Q", 1, 1, 128'h51, 0));

    // bytes received during WAIT_DONE are ignored
    stf0 = stf_cnt[0];
    send_line(mk("inject", 0, "Q", 1, 1, 128'h51, 0));
    exp_q.push_back({8'd1, 128'h51});
    expect_exec(0, "inject");
    send_byte(0, "Z");
    gap();
    send_byte(0, "Y");
    gap();
    send_byte(0, 8'h0D);
    repeat (4) @(negedge clk);
    check("inject len_held", get_len(0), 1);
    check("inject cmd_held", get_cmd(0), 128'h51);
    check("inject no_restart", stf_cnt[0] - stf0, 1);
    finish_exec(0, "inject");
    repeat (4) @(negedge clk);
    check("inject len_empty", get_len(0), 0);
    check("inject stfsm_total", stf_cnt[0] - stf0, 1);

    // reset during WAIT_DONE
    send_line(mk("rst_wait", 0, "Q", 1, 1, 128'h51, 0));
    exp_q.push_back({8'd1, 128'h51});
    expect_exec(0, "rst_wait");
    stf0 = stf_cnt[0];
    rst_n = 1'b0;
    #1;
    check("rst_wait busy", busy[0], 1'b0);
    check("rst_wait len", get_len(0), 0);
    check("rst_wait cmd", get_cmd(0), 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_wait no_stfsm", stf_cnt[0] - stf0, 0);
    check("rst_wait busy_low", busy[0], 1'b0);
    run_line(mk("after_rst", 0, "OK", 1, 2, 128'h4B4F, 0));

    check("scoreboard drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
